// File: rtl/adrv9001_pkg.sv
// Shared constants for the ADRV9001 TX pattern generator and future PRBS checkers.
// Mode codes, generator state encoding and the PRBS15 feedback taps.
package adrv9001_pkg;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_PRBS  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // x^15 + x^14 + 1: feedback is s[14] ^ s[13]
    localparam logic [14:0] PRBS15_TAPS = 15'h6000;

endpackage

// File: rtl/adrv9001_prbs15_x16.sv
// Advances a Fibonacci PRBS15 LFSR by 16 steps and returns the 16 generated bits.
// Latency: combinational. Backpressure: none, the caller decides when to load next_state.
// Bit 15 of bits is the first bit generated.
module adrv9001_prbs15_x16
    import adrv9001_pkg::*;
(
    input  logic [14:0] state,
    output logic [14:0] next_state,
    output logic [15:0] bits
);

    always_comb begin
        logic [14:0] s;
        logic        nb;
        s    = state;
        nb   = 1'b0;
        bits = '0;
        for (int i = 0; i < 16; i++) begin
            nb          = ^(s & PRBS15_TAPS);
            s           = {s[13:0], nb};
            bits[15-i]  = nb;
        end
        next_state = s;
    end

endmodule

// File: rtl/adrv9001_axis_pattern_gen.sv
// AXI4-Stream source of ramp / PRBS15 / constant IQ samples for the ADRV9001 TX path.
// Latency: first sample one cycle after enable is sampled; one beat per clock when tready is high.
// Backpressure: tdata/tlast held while tvalid && !tready; tvalid only drops after a handshake.
module adrv9001_axis_pattern_gen
    import adrv9001_pkg::*;
#(
    parameter int          COUNT_WIDTH = 32,
    parameter logic [14:0] PRBS_SEED   = 15'h7FFF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [15:0]            ramp_step,
    input  logic [31:0]            const_data,
    input  logic [COUNT_WIDTH-1:0] burst_len,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] beat_count
);

    // An all-zero seed would lock the LFSR up
    localparam logic [14:0] SEED = (PRBS_SEED == 15'd0) ? 15'h0001 : PRBS_SEED;

    state_t                 state;
    state_t                 state_next;
    logic [1:0]             mode_q;
    logic [15:0]            step_q;
    logic [31:0]            const_q;
    logic [COUNT_WIDTH-1:0] burst_q;
    logic [15:0]            ramp_i;
    logic [14:0]            lfsr;
    logic                   stop_req;

    logic                   accept;
    logic [14:0]            prbs_state;
    logic [14:0]            prbs_next;
    logic [15:0]            prbs_bits;
    logic [1:0]             mode_src;
    logic [15:0]            i_src;
    logic [31:0]            const_src;
    logic [31:0]            sample;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   start_last;
    logic                   next_last;

    assign accept = m_axis_tvalid && m_axis_tready;
    assign busy   = (state == ST_RUN);

    adrv9001_prbs15_x16 u_prbs (
        .state      (prbs_state),
        .next_state (prbs_next),
        .bits       (prbs_bits)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable) state_next = ST_RUN;
            ST_RUN: begin
                if (accept) begin
                    if (m_axis_tlast)              state_next = ST_DONE;
                    else if (!enable || stop_req)  state_next = ST_IDLE;
                end
            end
            ST_DONE: if (!enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // In IDLE the first sample is built from the live inputs being latched this cycle
    always_comb begin
        prbs_state = SEED;
        mode_src   = mode;
        i_src      = 16'h0000;
        const_src  = const_data;
        if (state == ST_RUN) begin
            prbs_state = lfsr;
            mode_src   = mode_q;
            i_src      = ramp_i + step_q;
            const_src  = const_q;
        end
        case (mode_src)
            MODE_RAMP: sample = {i_src, 16'h0000 - i_src};
            MODE_PRBS: sample = {prbs_bits, ~prbs_bits};
            default:   sample = const_src;
        endcase
    end

    assign count_inc  = (&beat_count) ? beat_count : beat_count + COUNT_WIDTH'(1);
    assign start_last = (burst_len == COUNT_WIDTH'(1));
    // The beat presented after this acceptance is number beat_count+2
    assign next_last  = (burst_q != '0) &&
                        (({1'b0, beat_count} + (COUNT_WIDTH+1)'(2)) == {1'b0, burst_q});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            done          <= 1'b0;
            beat_count    <= '0;
            mode_q        <= MODE_RAMP;
            step_q        <= '0;
            const_q       <= '0;
            burst_q       <= '0;
            ramp_i        <= '0;
            lfsr          <= SEED;
            stop_req      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        mode_q        <= mode;
                        step_q        <= ramp_step;
                        const_q       <= const_data;
                        burst_q       <= burst_len;
                        beat_count    <= '0;
                        ramp_i        <= 16'h0000;
                        lfsr          <= prbs_next;
                        m_axis_tdata  <= sample;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= start_last;
                        stop_req      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!enable) stop_req <= 1'b1;
                    if (accept) begin
                        beat_count <= count_inc;
                        if (state_next == ST_RUN) begin
                            ramp_i       <= i_src;
                            lfsr         <= prbs_next;
                            m_axis_tdata <= sample;
                            m_axis_tlast <= next_last;
                        end else begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            done          <= (state_next == ST_DONE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adrv9001_axis_pattern_gen.md
Name: adrv9001_axis_pattern_gen

Overview:
- AXI4-Stream master that sources deterministic IQ test patterns (ramp, PRBS15, constant) into the ADRV9001 TX datapath in place of DMA data.
- It is the driving end of the tdata/tvalid/tready stream that the TX debug ILA taps.
- Used for bring-up, loopback BER checks and interface eye/skew validation.
- Sample format: tdata[31:16] = I, tdata[15:0] = Q, both 16-bit two's complement.

Parameters:
- COUNT_WIDTH, 32: width of burst_len and beat_count.
- PRBS_SEED, 15'h7FFF: LFSR load value at each start. A value of zero is illegal; the block forces it to 15'h0001.

Ports:
- clk  input  1  stream clock (TX sample clock domain)
- rstn  input  1  asynchronous active-low reset
- enable  input  1  level; high starts or continues generation, low stops it
- mode  input  2  0=ramp, 1=PRBS15, 2=constant, 3=reserved (behaves as constant)
- ramp_step  input  16  increment applied to I per accepted beat
- const_data  input  32  value emitted in constant mode
- burst_len  input  COUNT_WIDTH  number of beats per run; 0 = continuous
- m_axis_tdata  output  32  pattern sample
- m_axis_tvalid  output  1  sample valid
- m_axis_tready  input  1  sink ready
- m_axis_tlast  output  1  high on the final beat of a finite burst
- busy  output  1  high in the RUN state
- done  output  1  one-cycle pulse when a finite burst completes
- beat_count  output  COUNT_WIDTH  beats accepted since the last start; saturates at all-ones

Behaviour:
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, beat_count=0, state=IDLE, LFSR=seed, ramp accumulator=0.
- Beat acceptance: a beat is accepted on any cycle where tvalid && tready.
- State machine has three states: IDLE, RUN, DONE.
- IDLE -> RUN:
  - Triggered when enable=1 is sampled.
  - mode, ramp_step, const_data and burst_len are latched on this transition; later input changes are ignored until the next start.
  - beat_count, ramp accumulator and LFSR are cleared/reseeded.
  - tvalid rises on the next cycle with the first sample, giving a one-cycle start latency.
- RUN:
  - tvalid is held high.
  - tdata and tlast stay stable while tvalid && !tready.
  - The next sample is presented on the cycle after an acceptance. Back-to-back throughput is one beat per clock.
- RUN -> DONE:
  - Triggered by the accepted beat where beat_count+1 == burst_len (burst_len != 0).
  - tlast is high on that beat; tvalid drops on the next cycle.
  - done pulses for one cycle coincident with entry to DONE.
- DONE -> IDLE:
  - Taken when enable=0.
  - If enable stays high, the block stays in DONE and does not restart.
- Enable low during RUN:
  - A beat already presented and not yet accepted is still held until accepted; tvalid never drops without a handshake.
  - After that acceptance the block goes to IDLE, with no tlast and no done.
  - If enable=0 and an acceptance occur in the same cycle, the block goes to IDLE on the next cycle.
- Ramp mode:
  - First beat I=0.
  - I increments by ramp_step (modulo 2^16) per accepted beat.
  - Q = -I, two's complement, so I=16'h8000 gives Q=16'h8000.
- PRBS15 mode:
  - Polynomial x^15+x^14+1, Fibonacci form; the new bit is s[14]^s[13].
  - The LFSR advances 16 steps per accepted beat.
  - tdata[31:16] = the 16 generated bits, first generated bit in bit 31.
  - tdata[15:0] = bitwise inverse of tdata[31:16].
- Constant mode: tdata = latched const_data on every beat.
- beat_count increments per accepted beat and saturates in continuous mode.
- Reset asserted mid-run: all outputs go to their reset values immediately (asynchronous). The downstream sink must tolerate a tvalid drop caused by reset.

Decomposition:
- Shared package adrv9001_pkg contains:
  - Mode constants: MODE_RAMP=2'd0, MODE_PRBS=2'd1, MODE_CONST=2'd2.
  - The state encoding for IDLE/RUN/DONE.
  - The PRBS15 tap constant.
- One sub-module, adrv9001_prbs15_x16:
  - Combinational 16-step advance of the 15-bit state.
  - Inputs: state. Outputs: next state and 16 output bits.
  - Reusable by a future RX PRBS checker.

Test Plan:
1. Ramp, ramp_step=1, burst_len=4, tready=1 -> tdata = 0x00000000, 0x0001FFFF, 0x0002FFFE, 0x0003FFFD; tlast only on beat 4; done pulses once; beat_count=4; block stays in DONE until enable drops.
2. Constant 0x12345678, continuous, tready toggled 1,0,0,1 -> tdata and tvalid held stable through the stall; beat_count counts only the handshaked beats; tlast is never asserted.
3. PRBS15, seed 0x7FFF, burst_len=8 -> the 8 beats match the bench reference LFSR model bit-for-bit; tdata[15:0] == ~tdata[31:16] on every beat.
4. Enable dropped while tready=0 with a beat pending -> tvalid remains 1 until tready=1, that beat is accepted, then IDLE; no done, no tlast.
5. rstn pulled low mid-burst at beat 3 -> all outputs zero asynchronously; after release and enable, the burst restarts from I=0 / the seed.
6. Ramp with ramp_step=0x4000, continuous -> I sequence 0x0000, 0x4000, 0x8000, 0xC000, 0x0000 (wrap); Q at I=0x8000 equals 0x8000.
